sync_monitor: RTL and testbench

SYNC_MONITOR -- requirements
Module: sync_monitor

---
 rtl/sync_monitor.sv | 150 +++++++++++++++
 tb/tb_sync_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_monitor.sv
// Video timing monitor: measures hsync/vsync/video_on timing at pixel rate,
// recovers active-pixel coordinates and locks once a full frame matches.
module sync_monitor #(
  parameter int unsigned largo    = 10,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned HSYNC_W  = 96,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_tick,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             video_on,
  input  logic             clr_err,
  output logic [largo-1:0] rx_x,
  output logic [largo-1:0] rx_y,
  output logic             locked,
  output logic             frame_start,
  output logic             err,
  output logic             err_sticky,
  output logic [largo-1:0] h_period,
  output logic [largo-1:0] v_lines,
  output logic [largo-1:0] vs_width
);

  localparam int unsigned      XW      = largo + 1;
  localparam logic [largo-1:0] CNT_MAX = '1;
  localparam logic [largo-1:0] CNT_PRE = CNT_MAX - largo'(1);
  localparam logic [largo-1:0] CNT_ONE = largo'(1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             h_first, h_first_nx;
  logic             hs_q, vs_q, vo_q;
  logic [largo-1:0] tick_cnt, hs_low, v_cnt, vs_cnt;

  logic hs_fall, hs_rise, vs_fall, vs_rise, vo_fall;
  logic h_bad, timeout, hw_bad, act_bad, frm_bad, viol;

  // Edge detection, timing compares and next state for the current tick
  always_comb begin
    hs_fall = hs_q & ~hsync;
    hs_rise = ~hs_q & hsync;
    vs_fall = vs_q & ~vsync;
    vs_rise = ~vs_q & vsync;
    vo_fall = vo_q & ~video_on;

    h_bad   = hs_fall && !(state == MEASURE && h_first) && (tick_cnt != largo'(H_TOTAL));
    timeout = !hs_fall && (tick_cnt == CNT_PRE);
    hw_bad  = hs_rise && (hs_low != largo'(HSYNC_W));
    act_bad = vo_fall && ((XW'(rx_x) + XW'(1)) != XW'(H_ACTIVE));
    frm_bad = vs_fall && ((rx_y != largo'(V_ACTIVE)) || (v_cnt != largo'(V_TOTAL)));
    viol    = (state != SEARCH) && (h_bad || timeout || hw_bad || act_bad || frm_bad);

    state_nx   = state;
    h_first_nx = h_first;
    unique case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nx   = MEASURE;
          h_first_nx = 1'b1;
        end
      end
      MEASURE: begin
        if (hs_fall) h_first_nx = 1'b0;
        if (viol)         state_nx = SEARCH;
        else if (vs_fall) state_nx = LOCKED;
      end
      LOCKED: begin
        if (viol) state_nx = SEARCH;
      end
      default: state_nx = SEARCH;
    endcase
  end

  // All state and outputs advance only on pixel ticks; pulses last one clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEARCH;
      h_first     <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      vo_q        <= 1'b0;
      tick_cnt    <= '0;
      hs_low      <= '0;
      v_cnt       <= '0;
      vs_cnt      <= '0;
      rx_x        <= '0;
      rx_y        <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      err_sticky  <= 1'b0;
      h_period    <= '0;
      v_lines     <= '0;
      vs_width    <= '0;
    end else begin
      err         <= p_tick & viol;
      frame_start <= p_tick & vs_fall;
      if (p_tick) begin
        hs_q    <= hsync;
        vs_q    <= vsync;
        vo_q    <= video_on;
        state   <= state_nx;
        h_first <= h_first_nx;
        locked  <= (state_nx == LOCKED);

        if (hs_fall) begin
          h_period <= tick_cnt;
          tick_cnt <= CNT_ONE;
        end else if (tick_cnt != CNT_MAX) begin
          tick_cnt <= tick_cnt + CNT_ONE;
        end

        if (hs_fall)                          hs_low <= CNT_ONE;
        else if (!hsync && hs_low != CNT_MAX) hs_low <= hs_low + CNT_ONE;

        if (video_on) rx_x <= vo_q ? rx_x + CNT_ONE : '0;

        if (vs_fall)      rx_y <= '0;
        else if (vo_fall) rx_y <= rx_y + CNT_ONE;

        // A line whose hsync falls with vsync belongs to the new frame
        if (vs_fall) begin
          v_lines <= v_cnt;
          v_cnt   <= hs_fall ? CNT_ONE : '0;
        end else if (hs_fall && v_cnt != CNT_MAX) begin
          v_cnt <= v_cnt + CNT_ONE;
        end

        if (vs_fall)                                   vs_cnt <= hs_fall ? CNT_ONE : '0;
        else if (!vsync && hs_fall && vs_cnt != CNT_MAX) vs_cnt <= vs_cnt + CNT_ONE;

        if (vs_rise) vs_width <= vs_cnt;

        if (viol)                 err_sticky <= 1'b1;
        else if (clr_err && !err) err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_monitor.sv
// Bench for sync_monitor: scaled-down video timing streams, timestamp-based
// reference model, directed fault frames followed by randomized frames.
module tb_sync_monitor;

  localparam int unsigned LG = 6;
  localparam int unsigned HA = 16;
  localparam int unsigned HT = 24;
  localparam int unsigned HW = 4;
  localparam int unsigned VA = 6;
  localparam int unsigned VT = 10;
  localparam int MAXV     = (1 << LG) - 1;
  localparam int H_VO0    = 6;
  localparam int V_VO0    = 3;
  localparam int VS_LINES = 2;

  logic          clk = 1'b0;
  logic          rst, p_tick, hsync, vsync, video_on, clr_err;
  logic [LG-1:0] rx_x, rx_y, h_period, v_lines, vs_width;
  logic          locked, frame_start, err, err_sticky;

  int n_checks = 0;
  int n_errors = 0;
  int dut_err_cnt = 0;

  // reference model state (tick timestamps rather than counters)
  int t = 0, mode = 0;
  bit skip, ph, pv, po;
  int t_hf, t_hsl, t_vor, vcnt, vsn;
  int e_x, e_y, e_hp, e_vl, e_vw;
  bit e_lock, e_fs, e_err, e_sticky;

  sync_monitor #(
    .largo(LG), .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_W(HW), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst(rst), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .clr_err(clr_err), .rx_x(rx_x), .rx_y(rx_y),
    .locked(locked), .frame_start(frame_start), .err(err), .err_sticky(err_sticky),
    .h_period(h_period), .v_lines(v_lines), .vs_width(vs_width)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (err === 1'b1) dut_err_cnt <= dut_err_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic check_all();
    chk("rx_x", int'(rx_x), e_x);
    chk("rx_y", int'(rx_y), e_y);
    chk("locked", int'(locked), int'(e_lock));
    chk("frame_start", int'(frame_start), int'(e_fs));
    chk("err", int'(err), int'(e_err));
    chk("err_sticky", int'(err_sticky), int'(e_sticky));
    chk("h_period", int'(h_period), e_hp);
    chk("v_lines", int'(v_lines), e_vl);
    chk("vs_width", int'(vs_width), e_vw);
  endtask

  task automatic model_reset();
    mode = 0; skip = 0; ph = 0; pv = 0; po = 0;
    t_hf = t; t_hsl = t; t_vor = t; vcnt = 0; vsn = 0;
    e_x = 0; e_y = 0; e_hp = 0; e_vl = 0; e_vw = 0;
    e_lock = 0; e_fs = 0; e_err = 0; e_sticky = 0;
  endtask

  task automatic model_tick(input bit hs, input bit vs, input bit vo, input bit clr);
    bit hf, hr, vf, vr, vof, act, viol;
    hf = ph && !hs;  hr = !ph && hs;
    vf = pv && !vs;  vr = !pv && vs;
    vof = po && !vo;
    act = (mode != 0);
    viol = 0;
    if (hf) begin
      if (act && !(mode == 1 && skip) && sat(t - t_hf) != HT) viol = 1;
      e_hp = sat(t - t_hf);
      t_hf = t;
      t_hsl = t;
    end else if (act && (t - t_hf) == MAXV - 1) begin
      viol = 1;
    end
    if (hr && act && sat(t - t_hsl) != HW) viol = 1;
    if (vof && act && (t - t_vor) != HA) viol = 1;
    if (vo) begin
      if (!po) t_vor = t;
      e_x = (t - t_vor) % (MAXV + 1);
    end
    if (vf) begin
      if (act && (e_y != VA || vcnt != VT)) viol = 1;
      e_vl = vcnt;
      vcnt = hf ? 1 : 0;
      vsn  = hf ? 1 : 0;
      e_y  = 0;
    end else begin
      if (vof) e_y = (e_y + 1) % (MAXV + 1);
      if (hf) vcnt = sat(vcnt + 1);
      if (hf && !vs) vsn = sat(vsn + 1);
    end
    if (vr) e_vw = vsn;
    if (viol) e_sticky = 1;
    else if (clr && !e_err) e_sticky = 0;
    case (mode)
      0: if (vf) begin mode = 1; skip = 1; end
      1: begin
        if (hf) skip = 0;
        if (viol) mode = 0;
        else if (vf) mode = 2;
      end
      default: if (viol) mode = 0;
    endcase
    e_err = viol;
    e_fs = vf;
    e_lock = (mode == 2);
    ph = hs; pv = vs; po = vo;
    t++;
  endtask

  task automatic do_tick(input bit hs, input bit vs, input bit vo, input bit clr, input int gap);
    @(negedge clk);
    p_tick = 1'b1; hsync = hs; vsync = vs; video_on = vo; clr_err = clr;
    @(posedge clk); #1;
    model_tick(hs, vs, vo, clr);
    check_all();
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      p_tick = 1'b0; clr_err = 1'b0;
      @(posedge clk); #1;
      e_err = 0; e_fs = 0;
      check_all();
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_tick(1'b1, 1'b1, 1'b0, 1'b0, 1);
  endtask

  // kind: 0 none, 1 line length HT+amt, 2 hsync width HW+amt, 3 hsync stuck high
  task automatic send_frame(input int bad_line, input int kind, input int amt, input int act_w,
                            input int n_lines, input int clr_line, input int clr_pix,
                            input bit gap_rand);
    for (int y = 0; y < n_lines; y++) begin
      int len, hw;
      len = HT; hw = HW;
      if (y == bad_line) begin
        if (kind == 1) len = HT + amt;
        if (kind == 2) hw = HW + amt;
        if (kind == 3) len = MAXV + 8;
      end
      for (int i = 0; i < len; i++) begin
        bit hs, vs, vo, clr;
        hs  = (i >= hw);
        vs  = (y >= VS_LINES);
        vo  = (y >= V_VO0) && (y < V_VO0 + VA) && (i >= H_VO0) && (i < H_VO0 + act_w);
        clr = (y == clr_line) && (i == clr_pix);
        do_tick(hs, vs, vo, clr, gap_rand ? int'($urandom_range(1, 3)) : 1);
      end
    end
  endtask

  task automatic nominal(input int n);
    for (int k = 0; k < n; k++) send_frame(-1, 0, 0, HA, VT, -1, 0, 1'b0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1; video_on = 1'b0; clr_err = 1'b0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    @(negedge clk) rst = 1'b1;
    idle(3);

    // nominal stream locks on the second vsync fall
    d0 = dut_err_cnt;
    nominal(1);
    chk("lock_after_first_frame", int'(locked), 0);
    nominal(2);
    chk("lock_nominal", int'(locked), 1);
    chk("h_period_nominal", int'(h_period), HT);
    chk("v_lines_nominal", int'(v_lines), VT);
    chk("vs_width_nominal", int'(vs_width), VS_LINES);
    chk("no_err_nominal", dut_err_cnt - d0, 0);

    // one line one tick too long
    d0 = dut_err_cnt;
    send_frame(4, 1, 1, HA, VT, -1, 0, 1'b0);
    chk("long_line_err_pulses", dut_err_cnt - d0, 1);
    chk("long_line_unlock", int'(locked), 0);
    chk("long_line_sticky", int'(err_sticky), 1);
    nominal(2);
    chk("relock_after_long_line", int'(locked), 1);

    // clr_err alone clears, clr_err coincident with err keeps sticky
    send_frame(-1, 0, 0, HA, VT, 2, 10, 1'b0);
    chk("sticky_cleared", int'(err_sticky), 0);
    send_frame(4, 1, 1, HA, VT, 5, 0, 1'b0);
    chk("sticky_kept_on_coincident_clr", int'(err_sticky), 1);
    nominal(2);

    // hsync stuck high until the tick counter saturates
    d0 = dut_err_cnt;
    send_frame(4, 3, 0, HA, VT, -1, 0, 1'b0);
    chk("timeout_err_pulses", dut_err_cnt - d0, 1);
    chk("timeout_unlock", int'(locked), 0);
    nominal(2);
    chk("relock_after_timeout", int'(locked), 1);

    // active rows one pixel short never lock
    d0 = dut_err_cnt;
    for (int k = 0; k < 3; k++) send_frame(-1, 0, 0, HA - 1, VT, -1, 0, 1'b0);
    chk("short_rows_err_pulses", dut_err_cnt - d0, 3);
    chk("short_rows_no_lock", int'(locked), 0);
    chk("short_rows_last_x", int'(rx_x), HA - 2);

    // reset mid-frame
    nominal(2);
    send_frame(-1, 0, 0, HA, VT, -1, 0, 1'b0);
    send_frame(-1, 0, 0, HA, 5, -1, 0, 1'b0);
    @(negedge clk) rst = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    idle(3);
    nominal(1);
    chk("reset_lock_after_one_frame", int'(locked), 0);
    nominal(1);
    chk("reset_relock", int'(locked), 1);

    // randomized frames with assorted faults, clears and tick spacing
    for (int f = 0; f < 12; f++) begin
      int kind, bl, amt, aw, cl;
      kind = int'($urandom_range(0, 4));
      bl   = int'($urandom_range(1, VT - 3));
      amt  = 0;
      aw   = HA;
      if (kind == 1) begin
        amt = int'($urandom_range(0, 4)) - 2;
        if (amt >= 0) amt++;
      end else if (kind == 2) begin
        amt = ($urandom_range(0, 1) == 0) ? -1 : 1;
      end else if (kind == 4) begin
        aw = HA - 3 + int'($urandom_range(0, 4));
        if (aw >= HA) aw++;
        kind = 0;
      end
      cl = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, VT - 1));
      send_frame(bl, kind, amt, aw, VT, cl, int'($urandom_range(0, HT - 1)), 1'b1);
    end
    nominal(2);
    chk("final_lock", int'(locked), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
